// File: rtl/div_ctrl_pkg.sv
// Shared widths, state encodings and handshake constants for the divide sequencer.
// Optional zero-divisor short-cut is selected by the DIV_BYZERO_DETECT_EN macro.
package div_ctrl_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 64;
  localparam int unsigned CntW         = 6;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  typedef struct packed {
    logic [RegBus-1:0] rem;
    logic [RegBus-1:0] quo;
  } div_result_t;

  // Magnitude of a signed operand; -2^31 maps to 0x80000000 read as unsigned.
  function automatic logic [RegBus-1:0] abs_val(input logic [RegBus-1:0] x, input logic is_signed);
    return (is_signed && x[RegBus-1]) ? RegBus'(~x + RegBus'(1)) : x;
  endfunction

  function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] x, input logic en);
    return en ? RegBus'(~x + RegBus'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} work register.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [RegBus:0]   rem_i,
  input  logic [RegBus-1:0] quo_i,
  input  logic [RegBus-1:0] divisor_i,
  output logic [RegBus:0]   rem_o,
  output logic [RegBus-1:0] quo_o
);

  logic [RegBus:0]   rem_sh;
  logic [RegBus-1:0] quo_sh;
  logic [RegBus:0]   dvs_ext;

  always_comb begin
    rem_sh  = {rem_i[RegBus-1:0], quo_i[RegBus-1]};
    quo_sh  = {quo_i[RegBus-2:0], 1'b0};
    dvs_ext = {1'b0, divisor_i};
    rem_o   = rem_sh;
    quo_o   = quo_sh;
    if (rem_sh >= dvs_ext) begin
      rem_o = rem_sh - dvs_ext;
      quo_o = {quo_sh[RegBus-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// 32-step restoring divide sequencer with sign fix-up, annul and ready handshake.
// Build with DIV_BYZERO_DETECT_EN to short-cut zero divisors through BYZERO.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  div_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [RegBus:0]         rem_q, rem_d;
  logic [RegBus-1:0]       quo_q, quo_d;
  logic [RegBus-1:0]       dvs_q, dvs_d;
  logic                    quo_neg_q, quo_neg_d;
  logic                    rem_neg_q, rem_neg_d;
  div_result_t             result_q, result_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic [RegBus:0]         step_rem;
  logic [RegBus-1:0]       step_quo;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = '0;

    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          rem_d     = '0;
          quo_d     = abs_val(opdata1_i, signed_div_i);
          dvs_d     = abs_val(opdata2_i, signed_div_i);
          quo_neg_d = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
          rem_neg_d = signed_div_i & opdata1_i[RegBus-1];
          cnt_d     = '0;
`ifdef DIV_BYZERO_DETECT_EN
          state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
`else
          state_d   = DivOn;
`endif
        end
      end
`ifdef DIV_BYZERO_DETECT_EN
      DivByZero: begin
        result_d = '0;
        state_d  = DivEnd;
      end
`endif
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(RegBus - 1)) begin
            result_d.rem = neg_if(step_rem[RegBus-1:0], rem_neg_q);
            result_d.quo = neg_if(step_quo, quo_neg_q);
            state_d      = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          state_d = DivFree;
        end else begin
          result_d = result_q;
        end
      end
      default: state_d = DivFree;
    endcase

    ready_d = (state_d == DivEnd) ? DivResultReady : DivResultNotReady;
    busy_d  = (state_d != DivFree);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule
